// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one multi-cycle resource among four requesters.
// It drives the operand mux select, pulses start, then waits for done or a watchdog timeout.
module mux4_rr_sched #(
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       res_done,
  output logic [1:0] select,
  output logic [3:0] grant,
  output logic       res_start,
  output logic [3:0] ack,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a requester raises req and holds it until its one-cycle ack;
  // the resource sees res_start for one cycle and answers with one res_done pulse.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_select;
  logic [3:0]       r_grant;
  logic [3:0]       r_ack;
  logic             r_timeout;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0] w_elig;
  logic [1:0] w_win;
  logic       w_found;

  // A requester whose ack is visible this cycle is masked so it is not re-granted at once.
  always_comb begin
    w_elig  = req & ~r_ack;
    w_win   = 2'd0;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] idx;
      idx = r_last + 2'(i);
      if (!w_found && w_elig[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_select  <= 2'd0;
      r_grant   <= 4'd0;
      r_ack     <= 4'd0;
      r_timeout <= 1'b0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
    end else begin
      r_ack     <= 4'd0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_select <= w_win;
            r_grant  <= 4'b0001 << w_win;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (res_done) begin
            r_ack   <= r_grant;
            r_last  <= r_select;
            r_grant <= 4'd0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_last    <= r_select;
            r_grant   <= 4'd0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign select    = r_select;
  assign grant     = r_grant;
  assign ack       = r_ack;
  assign timeout   = r_timeout;
  assign res_start = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule
